// File: rtl/fft_peak_detect.sv
// Peak-bin search over the lower half of an FFT output frame. Reports the peak's index and its re^2+im^2 once per frame.
// Optional build macro FFT_PEAK_DC_SKIP_EN drops bins 0 and 1 from the search.
module fft_peak_detect #(
  parameter int FFT_POINT = 1024,
  parameter int DATA_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_fft_valid,
  input  logic signed [DATA_W-1:0]     i_fft_re,
  input  logic signed [DATA_W-1:0]     i_fft_im,
  input  logic                         i_fft_last,
  output logic                         o_peak_valid,
  output logic [$clog2(FFT_POINT)-1:0] o_peak_index,
  output logic [2*DATA_W-1:0]          o_peak_mag,
  output logic                         o_frame_err
);

  localparam int IW = $clog2(FFT_POINT);
  localparam int SW = 2*DATA_W-1;
  localparam int MW = 2*DATA_W;
  localparam logic [IW-1:0] LAST_IDX = IW'(FFT_POINT-1);
`ifdef FFT_PEAK_DC_SKIP_EN
  localparam logic [IW-1:0] FIRST_IDX = IW'(2);
`else
  localparam logic [IW-1:0] FIRST_IDX = '0;
`endif

  typedef enum logic [1:0] {ACC, DONE, ERR} state_t;

  logic [IW-1:0]            r_bin_cnt;

  logic                     r_s1_valid;
  logic                     r_s1_last;
  logic [IW-1:0]            r_s1_idx;
  logic signed [DATA_W-1:0] r_s1_re;
  logic signed [DATA_W-1:0] r_s1_im;

  logic                     r_s2_valid;
  logic                     r_s2_last;
  logic [IW-1:0]            r_s2_idx;
  logic [SW-1:0]            r_s2_sq_re;
  logic [SW-1:0]            r_s2_sq_im;

  state_t                   r_state;
  logic [MW-1:0]            r_max_mag;
  logic [IW-1:0]            r_max_idx;

  logic signed [SW-1:0]     w_re_ext;
  logic signed [SW-1:0]     w_im_ext;
  logic signed [SW-1:0]     w_sq_re;
  logic signed [SW-1:0]     w_sq_im;
  logic [MW-1:0]            w_mag;
  logic                     w_dc_skip;
  logic                     w_in_win;
  logic                     w_first;
  logic                     w_load;
  logic                     w_idx_last;
  logic                     w_end_ok;
  logic                     w_end_err;

  // Bin counter: restarts after a marked last bin or after the final index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin_cnt <= '0;
    end else if (i_fft_valid) begin
      if (i_fft_last || (r_bin_cnt == LAST_IDX))
        r_bin_cnt <= '0;
      else
        r_bin_cnt <= r_bin_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_idx   <= '0;
      r_s1_re    <= '0;
      r_s1_im    <= '0;
    end else begin
      r_s1_valid <= i_fft_valid;
      r_s1_last  <= i_fft_valid & i_fft_last;
      r_s1_idx   <= r_bin_cnt;
      r_s1_re    <= i_fft_re;
      r_s1_im    <= i_fft_im;
    end
  end

  // Squares are computed at 2*DATA_W-1 bits; the result is never negative, so the top bit is a magnitude bit.
  assign w_re_ext = {{(DATA_W-1){r_s1_re[DATA_W-1]}}, r_s1_re};
  assign w_im_ext = {{(DATA_W-1){r_s1_im[DATA_W-1]}}, r_s1_im};
  assign w_sq_re  = w_re_ext * w_re_ext;
  assign w_sq_im  = w_im_ext * w_im_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_idx   <= '0;
      r_s2_sq_re <= '0;
      r_s2_sq_im <= '0;
    end else begin
      r_s2_valid <= r_s1_valid;
      r_s2_last  <= r_s1_last;
      r_s2_idx   <= r_s1_idx;
      r_s2_sq_re <= w_sq_re;
      r_s2_sq_im <= w_sq_im;
    end
  end

  assign w_mag = {1'b0, r_s2_sq_re} + {1'b0, r_s2_sq_im};

`ifdef FFT_PEAK_DC_SKIP_EN
  assign w_dc_skip = (r_s2_idx < IW'(2));
`else
  assign w_dc_skip = 1'b0;
`endif

  assign w_in_win   = r_s2_valid && !r_s2_idx[IW-1] && !w_dc_skip;
  assign w_first    = (r_s2_idx == FIRST_IDX);
  assign w_load     = w_in_win && (w_first || (w_mag > r_max_mag));
  assign w_idx_last = (r_s2_idx == LAST_IDX);
  assign w_end_ok   = r_s2_valid && r_s2_last && w_idx_last;
  assign w_end_err  = r_s2_valid && (r_s2_last != w_idx_last);

  // A bin compared in the DONE/ERR cycle starts the next frame.
  // Its load therefore wins over the end-of-frame clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ACC;
      r_max_mag    <= '0;
      r_max_idx    <= '0;
      o_peak_valid <= 1'b0;
      o_peak_index <= '0;
      o_peak_mag   <= '0;
      o_frame_err  <= 1'b0;
    end else begin
      o_peak_valid <= 1'b0;
      o_frame_err  <= 1'b0;
      unique case (r_state)
        DONE: begin
          o_peak_valid <= 1'b1;
          o_peak_index <= r_max_idx;
          o_peak_mag   <= r_max_mag;
        end
        ERR: o_frame_err <= 1'b1;
        default: ;
      endcase

      if (w_load) begin
        r_max_mag <= w_mag;
        r_max_idx <= r_s2_idx;
      end else if (r_state != ACC) begin
        r_max_mag <= '0;
        r_max_idx <= '0;
      end

      if (w_end_ok)
        r_state <= DONE;
      else if (w_end_err)
        r_state <= ERR;
      else
        r_state <= ACC;
    end
  end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Directed bench for fft_peak_detect: table of frames plus back-to-back and mid-frame reset sequences.
module tb_fft_peak_detect;
  localparam int N  = 1024;
  localparam int DW = 16;
  localparam int IW = 10;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 i_fft_valid = 1'b0;
  logic                 i_fft_last = 1'b0;
  logic signed [DW-1:0] i_fft_re = '0;
  logic signed [DW-1:0] i_fft_im = '0;
  logic                 o_peak_valid;
  logic [IW-1:0]        o_peak_index;
  logic [2*DW-1:0]      o_peak_mag;
  logic                 o_frame_err;

  fft_peak_detect #(.FFT_POINT(N), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .i_fft_valid(i_fft_valid), .i_fft_re(i_fft_re),
    .i_fft_im(i_fft_im), .i_fft_last(i_fft_last), .o_peak_valid(o_peak_valid),
    .o_peak_index(o_peak_index), .o_peak_mag(o_peak_mag), .o_frame_err(o_frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int              cyc;
    logic [1:0]      kind;
    logic [IW-1:0]   idx;
    logic [2*DW-1:0] mag;
  } ev_t;
  ev_t ev_q[$];

  always @(posedge clk) begin
    #1;
    if (o_peak_valid || o_frame_err)
      ev_q.push_back('{cyc, {o_peak_valid, o_frame_err}, o_peak_index, o_peak_mag});
  end

  typedef struct {
    string  name;
    int     n_bins;
    int     last_at;
    bit     gaps;
    int     bg_re, bg_im;
    int     p0, r0, i0;
    int     p1, r1, i1;
    int     p2, r2, i2;
    bit     exp_err;
    longint exp_idx;
    longint exp_mag;
  } tc_t;

  int n_checks = 0;
  int n_errors = 0;

  function automatic tc_t mk(input string name, input int n_bins, input int last_at, input bit gaps,
                             input int bg_re, input int bg_im,
                             input int p0, input int r0, input int i0,
                             input int p1, input int r1, input int i1,
                             input int p2, input int r2, input int i2,
                             input bit exp_err, input longint exp_idx, input longint exp_mag);
    tc_t t;
    t.name = name; t.n_bins = n_bins; t.last_at = last_at; t.gaps = gaps;
    t.bg_re = bg_re; t.bg_im = bg_im;
    t.p0 = p0; t.r0 = r0; t.i0 = i0;
    t.p1 = p1; t.r1 = r1; t.i1 = i1;
    t.p2 = p2; t.r2 = r2; t.i2 = i2;
    t.exp_err = exp_err; t.exp_idx = exp_idx; t.exp_mag = exp_mag;
    return t;
  endfunction

  function automatic logic [2*DW-1:0] bin_val(input tc_t t, input int b);
    int re;
    int im;
    re = t.bg_re; im = t.bg_im;
    if (b == t.p0) begin re = t.r0; im = t.i0; end
    if (b == t.p1) begin re = t.r1; im = t.i1; end
    if (b == t.p2) begin re = t.r2; im = t.i2; end
    return {16'(re), 16'(im)};
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_event(input string nm, input int acc, input logic [1:0] kind,
                             input longint idx, input longint mag);
    ev_t e;
    if (ev_q.size() == 0) begin
      chk({nm, " pulse present"}, 0, 1);
      return;
    end
    e = ev_q.pop_front();
    chk({nm, " pulse kind {valid,err}"}, longint'(e.kind), longint'(kind));
    chk({nm, " latency"}, e.cyc - acc, 3);
    chk({nm, " index"}, longint'(e.idx), idx);
    chk({nm, " mag"}, longint'(e.mag), mag);
  endtask

  // Drives one frame; idle cycles only before bins > 0, so consecutive calls are back-to-back.
  task automatic send(input tc_t t, output int acc);
    acc = 0;
    for (int b = 0; b < t.n_bins; b++) begin
      if (t.gaps && b > 0 && $urandom_range(0, 1) == 1) begin
        @(negedge clk);
        i_fft_valid = 1'b0; i_fft_last = 1'b0;
        i_fft_re = 16'sh7fff; i_fft_im = -16'sh7fff;
      end
      @(negedge clk);
      i_fft_valid = 1'b1;
      i_fft_last  = (b == t.last_at);
      {i_fft_re, i_fft_im} = bin_val(t, b);
      @(posedge clk);
      #1 acc = cyc;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    i_fft_valid = 1'b0; i_fft_last = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    tc_t tcs[$];
    tc_t b2b[3];
    tc_t part, post;
    int  acc;
    int  accs[3];
    longint dc_idx, dc_mag, z_idx, b0_idx, b0_mag;

`ifdef FFT_PEAK_DC_SKIP_EN
    dc_idx = 5; dc_mag = 10000;     z_idx = 2; b0_idx = 2; b0_mag = 100;
`else
    dc_idx = 0; dc_mag = 400000000; z_idx = 0; b0_idx = 0; b0_mag = 400000000;
`endif

    tcs.push_back(mk("tone",    1024, 1023, 0, 10, 0,  37, 1000, -1000, -1, 0, 0, -1, 0, 0, 0, 37, 2000000));
    tcs.push_back(mk("short",    512,  511, 0, 10, 0, 100, 5000, 0,     -1, 0, 0, -1, 0, 0, 1, 37, 2000000));
    tcs.push_back(mk("tie",     1024, 1023, 1, 10, 0,  50, 300, 400,    80, 300, 400, 700, 30000, 0, 0, 50, 250000));
    tcs.push_back(mk("long",    1024,   -1, 0, 10, 0,   3, 2000, 0,     -1, 0, 0, -1, 0, 0, 1, 50, 250000));
    tcs.push_back(mk("extreme", 1024, 1023, 0, 10, 0,   5, -32768, -32768, -1, 0, 0, -1, 0, 0, 0, 5, 64'h8000_0000));
    tcs.push_back(mk("window",  1024, 1023, 0, 10, 0, 511, 500, 0,     512, 600, 0, -1, 0, 0, 0, 511, 250000));
    tcs.push_back(mk("dc",      1024, 1023, 0,  1, 1,   0, 20000, 0,     5, 100, 0, -1, 0, 0, 0, dc_idx, dc_mag));
    tcs.push_back(mk("zero",    1024, 1023, 0,  0, 0,  -1, 0, 0,        -1, 0, 0, -1, 0, 0, 0, z_idx, 0));

    repeat (3) @(posedge clk);
    #1;
    chk("reset o_peak_valid", o_peak_valid, 0);
    chk("reset o_frame_err",  o_frame_err, 0);
    chk("reset o_peak_index", o_peak_index, 0);
    chk("reset o_peak_mag",   o_peak_mag, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int k = 0; k < tcs.size(); k++) begin
      send(tcs[k], acc);
      idle();
      repeat (8) @(posedge clk);
      #1;
      check_event(tcs[k].name, acc, tcs[k].exp_err ? 2'b01 : 2'b10, tcs[k].exp_idx, tcs[k].exp_mag);
      chk({tcs[k].name, " extra pulses"}, ev_q.size(), 0);
    end

    b2b[0] = mk("b2b12",  1024, 1023, 1, 10, 0,  12, 500, 500,   -1, 0, 0, -1, 0, 0, 0, 12, 500000);
    b2b[1] = mk("b2b300", 1024, 1023, 1, 10, 0, 300, -700, 100,  -1, 0, 0, -1, 0, 0, 0, 300, 500000);
    b2b[2] = mk("b2bdc",  1024, 1023, 1, 10, 0,   0, 20000, 0,   -1, 0, 0, -1, 0, 0, 0, b0_idx, b0_mag);
    for (int k = 0; k < 3; k++) send(b2b[k], accs[k]);
    idle();
    repeat (8) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++)
      check_event(b2b[k].name, accs[k], 2'b10, b2b[k].exp_idx, b2b[k].exp_mag);
    chk("b2b extra pulses", ev_q.size(), 0);

    part = mk("partial", 401, -1, 1, 10, 0, 100, 3000, 0, -1, 0, 0, -1, 0, 0, 0, 0, 0);
    send(part, acc);
    @(negedge clk);
    rst_n = 1'b0; i_fft_valid = 1'b0; i_fft_last = 1'b0;
    #1;
    chk("midreset o_peak_valid", o_peak_valid, 0);
    chk("midreset o_frame_err",  o_frame_err, 0);
    chk("midreset o_peak_index", o_peak_index, 0);
    chk("midreset o_peak_mag",   o_peak_mag, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("midreset no pulse", ev_q.size(), 0);

    post = mk("postreset", 1024, 1023, 0, 10, 0, 77, 300, 400, -1, 0, 0, -1, 0, 0, 0, 77, 250000);
    send(post, acc);
    idle();
    repeat (8) @(posedge clk);
    #1;
    check_event(post.name, acc, 2'b10, post.exp_idx, post.exp_mag);
    chk("postreset extra pulses", ev_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/fft_peak_detect.md
Name: fft_peak_detect

Overview:
- Sits directly downstream of the FFT core, which is fed by the two-channel FFT input packer.
- Consumes one FFT output frame of FFT_POINT complex bins and computes the squared magnitude re^2+im^2 of each bin.
- Tracks the largest magnitude in the lower half-spectrum (bins 0..FFT_POINT/2-1).
- Reports the peak bin index and magnitude once per frame; the frequency-measurement logic uses this result.

Parameters:
- FFT_POINT, 1024: bins per frame; power of two, >= 8.
- DATA_W, 16: signed width of FFT real/imag outputs.

Ports:
- clk  input  1  single system clock.
- rst_n  input  1  asynchronous, active-low reset.
- i_fft_valid  input  1  bin valid strobe; gaps allowed; no backpressure.
- i_fft_re  input  DATA_W  signed real part.
- i_fft_im  input  DATA_W  signed imaginary part.
- i_fft_last  input  1  marks the last bin of a frame; qualified by i_fft_valid.
- o_peak_valid  output  1  one-cycle pulse: new result available.
- o_peak_index  output  $clog2(FFT_POINT)  bin index of the peak; held until the next result.
- o_peak_mag  output  2*DATA_W  unsigned re^2+im^2 of the peak; held.
- o_frame_err  output  1  one-cycle pulse: frame length mismatch; frame discarded.

Behaviour:
- Reset (async assert, sync release): all outputs 0, bin counter 0, pipeline valids 0, running max 0, state ACC.
- Pipeline:
  - S1 registers re, im, valid, last and bin index.
  - S2 computes the squares: signed x signed, kept as unsigned 2*DATA_W-1 bits.
  - S3 computes the sum (2*DATA_W bits, no overflow; worst case (-2^(DATA_W-1))^2*2 = 2^(2*DATA_W-1)) and does the compare/update.
- Bin counter: increments on each accepted i_fft_valid; wraps FFT_POINT-1 -> 0.
- Search window: only bins with index < FFT_POINT/2 are compared. Bins >= FFT_POINT/2 are counted but ignored.
- Compare rule:
  - Update when mag > running max (strict), so on ties the lowest index wins.
  - The first bin in the window always loads the running max, even if its magnitude is 0.
- State machine (advances on the S3 registered stage):
  - ACC: accumulating a frame.
  - DONE: single cycle. Drive o_peak_valid=1, load o_peak_index/o_peak_mag from the running max, clear the running max, return to ACC.
  - ERR: single cycle. Drive o_frame_err=1, clear the running max, leave outputs unchanged, return to ACC.
- Frame end:
  - last=1 with bin index == FFT_POINT-1 -> DONE.
  - last=1 with index != FFT_POINT-1 (short frame) -> ERR.
  - Index == FFT_POINT-1 without last (long frame) -> ERR.
  - In both error cases the counter restarts at 0 for the next bin.
- Latency: o_peak_valid / o_frame_err rise exactly 3 clk after the cycle in which the final bin is accepted.
- Back-to-back frames: bin 0 of the next frame may arrive in the cycle after the last bin. The running-max clear in DONE/ERR must not lose that bin; the new bin's compare takes priority over the clear.
- Mid-frame reset: partial frame discarded, no pulse emitted; the first valid bin after release is bin 0.
- o_peak_valid and o_frame_err are never asserted in the same cycle.

Optional Feature:
- Macro FFT_PEAK_DC_SKIP_EN.
- Defined: bins 0 and 1 are excluded from the search (DC leakage). The first in-window bin is bin 2. If every remaining magnitude is 0, o_peak_index=2.
- Undefined: bin 0 is included. If every magnitude is 0, o_peak_index=0.

Test Plan:
- Single tone: FFT_POINT=1024, bin 37 = (1000, -1000), all others (10, 0), last on bin 1023 -> o_peak_valid pulse 3 clk after bin 1023; index=37; mag=2000000.
- Tie and upper half: bins 50 and 80 = (300, 400), bin 700 = (30000, 0) -> index=50, mag=250000. Bin 700 is ignored (upper half).
- Extremes: bin 5 = (-32768, -32768) -> mag=0x80000000, no overflow. DC_SKIP off with bin 0 the largest -> index 0; DC_SKIP on -> index 5.
- Length errors: last asserted at bin 511 -> o_frame_err pulse, no o_peak_valid, previous outputs held. 1024 bins with no last -> o_frame_err at the 1024th bin.
- Throughput and reset: two back-to-back frames, valid toggling 50% random, peaks at 12 then 300 -> two pulses with index 12 then 300. Then rst_n low at bin 400 of a third frame -> outputs 0, no pulse; the next full frame reports correctly.
